// File: rtl/seg_scan_driver.sv
// Six-digit common-anode 7-segment scanner with dwell blanking, leading-zero
// suppression and a frame-aligned load/acknowledge shadow register.
module seg_scan_driver #(
    parameter int N      = 10,
    parameter int DIGITS = 6,
    parameter int BLANK  = 4
) (
    input  logic        clk,
    input  logic        hard_reset,
    input  logic [23:0] digits_in,
    input  logic [5:0]  dp_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic        load_ack,
    output logic        frame_start,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [5:0]  an_n
);

    localparam logic [N-1:0] CNT_MAX  = '1;
    localparam logic [2:0]   LAST_IDX = 3'(DIGITS - 1);

    logic [N-1:0] cnt_q, cnt_d;
    logic [2:0]   idx_q, idx_d;
    logic [23:0]  shadow_dig_q, shadow_dig_d;
    logic [5:0]   shadow_dp_q, shadow_dp_d;
    logic [6:0]   seg_n_q, seg_n_d;
    logic         dp_n_q, dp_n_d;
    logic [5:0]   an_n_q, an_n_d;
    logic         load_ack_q, load_ack_d;
    logic         frame_start_q, frame_start_d;

    logic         boundary;
    logic         in_dwell_blank;
    logic         lz_blank;
    logic [3:0]   cur_dig;
    logic [5:0]   zero_from;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    generate
        if (BLANK == 0) begin : g_no_blank
            assign in_dwell_blank = 1'b0;
        end else begin : g_blank
            localparam logic [N-1:0] BLANK_CNT = N'(BLANK);
            assign in_dwell_blank = (cnt_q < BLANK_CNT);
        end
    endgenerate

    assign boundary = (cnt_q == CNT_MAX) && (idx_q == LAST_IDX);
    assign cur_dig  = shadow_dig_q[{idx_q, 2'b00} +: 4];

    // zero_from[i]: digit i and every digit to its left are zero with no dp lit.
    always_comb begin
        zero_from = '0;
        for (int i = 0; i < 6; i++) begin
            zero_from[i] = ((shadow_dig_q >> (4 * i)) == 24'd0) &&
                           ((shadow_dp_q >> i) == 6'd0);
        end
    end

    assign lz_blank = blank_lz && (idx_q != 3'd0) && zero_from[idx_q];

    always_comb begin
        cnt_d         = cnt_q + N'(1);
        idx_d         = idx_q;
        shadow_dig_d  = shadow_dig_q;
        shadow_dp_d   = shadow_dp_q;
        frame_start_d = boundary;
        load_ack_d    = boundary && load;

        if (cnt_q == CNT_MAX) begin
            idx_d = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
        end

        // The shadow only changes between frames so a frame never mixes values.
        if (boundary && load) begin
            shadow_dig_d = digits_in;
            shadow_dp_d  = dp_in;
        end
    end

    always_comb begin
        seg_n_d = 7'h7F;
        dp_n_d  = 1'b1;
        an_n_d  = 6'h3F;
        if (!in_dwell_blank && !lz_blank) begin
            an_n_d  = ~(6'd1 << idx_q);
            seg_n_d = seg_decode(cur_dig);
            dp_n_d  = ~shadow_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (hard_reset) begin
            cnt_q         <= '0;
            idx_q         <= 3'd0;
            shadow_dig_q  <= 24'd0;
            shadow_dp_q   <= 6'd0;
            seg_n_q       <= 7'h7F;
            dp_n_q        <= 1'b1;
            an_n_q        <= 6'h3F;
            load_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_dig_q  <= shadow_dig_d;
            shadow_dp_q   <= shadow_dp_d;
            seg_n_q       <= seg_n_d;
            dp_n_q        <= dp_n_d;
            an_n_q        <= an_n_d;
            load_ack_q    <= load_ack_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign load_ack    = load_ack_q;
    assign frame_start = frame_start_q;
    assign seg_n       = seg_n_q;
    assign dp_n        = dp_n_q;
    assign an_n        = an_n_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: decode vector table, handshake and
// reset corner sequences, and random traffic against a frame-position model.
module tb_seg_scan_driver;

    localparam int N     = 3;
    localparam int BLANK = 2;
    localparam int DWELL = 8;
    localparam int FRAME = 48;

    logic        clk = 1'b0;
    logic        hard_reset;
    logic [23:0] digits_in;
    logic [5:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic        load_ack;
    logic        frame_start;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [5:0]  an_n;

    always #5 clk = ~clk;

    seg_scan_driver #(.N(N), .DIGITS(6), .BLANK(BLANK)) dut (
        .clk         (clk),
        .hard_reset  (hard_reset),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .load        (load),
        .blank_lz    (blank_lz),
        .load_ack    (load_ack),
        .frame_start (frame_start),
        .seg_n       (seg_n),
        .dp_n        (dp_n),
        .an_n        (an_n)
    );

    typedef struct {
        logic [23:0] dig;
        logic [5:0]  dp;
        logic        lz;
        int          idx;
        logic [5:0]  an;
        logic [6:0]  seg;
        logic        dpn;
        logic        chk_seg;
    } vec_t;

    vec_t vecs[16];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: position within the 48-cycle frame plus the shadow value.
    int          pos   = 0;
    logic [23:0] m_dig = 24'd0;
    logic [5:0]  m_dp  = 6'd0;

    function automatic logic [6:0] ref_seg(input int v);
        case (v)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: predict from pre-edge inputs and model state, then compare.
    task automatic applyStimulus();
        int         idx;
        int         c;
        logic       lzb;
        logic [6:0] e_seg;
        logic       e_dp;
        logic [5:0] e_an;
        logic       e_ack;
        logic       e_fs;
        lzb   = 1'b0;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        e_an  = 6'h3F;
        e_ack = 1'b0;
        e_fs  = 1'b0;
        if (hard_reset) begin
            pos   = 0;
            m_dig = 24'd0;
            m_dp  = 6'd0;
        end else begin
            idx = pos / DWELL;
            c   = pos % DWELL;
            lzb = blank_lz && (idx != 0) && ((m_dig >> (4 * idx)) == 24'd0) &&
                  ((m_dp >> idx) == 6'd0);
            if (c >= BLANK && !lzb) begin
                e_an  = 6'h3F ^ (6'd1 << idx);
                e_seg = ref_seg(int'((m_dig >> (4 * idx)) & 24'hF));
                e_dp  = ~m_dp[idx];
            end
            e_fs  = (pos == FRAME - 1);
            e_ack = e_fs && load;
            if (e_ack) begin
                m_dig = digits_in;
                m_dp  = dp_in;
            end
            pos = (pos + 1) % FRAME;
        end
        @(posedge clk);
        #1;
        checkOutput("an_n", an_n, e_an);
        if (!lzb) begin
            checkOutput("seg_n", seg_n, e_seg);
            checkOutput("dp_n", dp_n, e_dp);
        end
        checkOutput("load_ack", load_ack, e_ack);
        checkOutput("frame_start", frame_start, e_fs);
    endtask

    initial begin
        int first_an;
        int first_fs;
        int acks;
        int bad_acks;

        vecs[0]  = '{24'h123456, 6'h00, 1'b0, 0, 6'b111110, 7'b0000010, 1'b1, 1'b1};
        vecs[1]  = '{24'h123456, 6'h00, 1'b0, 5, 6'b011111, 7'b1111001, 1'b1, 1'b1};
        vecs[2]  = '{24'h000070, 6'h00, 1'b1, 1, 6'b111101, 7'b1111000, 1'b1, 1'b1};
        vecs[3]  = '{24'h000070, 6'h00, 1'b1, 0, 6'b111110, 7'b1000000, 1'b1, 1'b1};
        vecs[4]  = '{24'h000070, 6'h00, 1'b1, 3, 6'b111111, 7'b1111111, 1'b1, 1'b0};
        vecs[5]  = '{24'h000070, 6'h08, 1'b1, 3, 6'b110111, 7'b1000000, 1'b0, 1'b1};
        vecs[6]  = '{24'h000070, 6'h08, 1'b1, 2, 6'b111011, 7'b1000000, 1'b1, 1'b1};
        vecs[7]  = '{24'h00000A, 6'h00, 1'b0, 0, 6'b111110, 7'b0111111, 1'b1, 1'b1};
        vecs[8]  = '{24'h0000F0, 6'h00, 1'b0, 1, 6'b111101, 7'b0111111, 1'b1, 1'b1};
        vecs[9]  = '{24'h987654, 6'h00, 1'b0, 1, 6'b111101, 7'b0010010, 1'b1, 1'b1};
        vecs[10] = '{24'h987654, 6'h00, 1'b0, 4, 6'b101111, 7'b0000000, 1'b1, 1'b1};
        vecs[11] = '{24'h987654, 6'h00, 1'b0, 5, 6'b011111, 7'b0010000, 1'b1, 1'b1};
        vecs[12] = '{24'h000020, 6'h00, 1'b0, 1, 6'b111101, 7'b0100100, 1'b1, 1'b1};
        vecs[13] = '{24'h000300, 6'h00, 1'b0, 2, 6'b111011, 7'b0110000, 1'b1, 1'b1};
        vecs[14] = '{24'h000070, 6'h00, 1'b0, 5, 6'b011111, 7'b1000000, 1'b1, 1'b1};
        vecs[15] = '{24'h987654, 6'h01, 1'b0, 0, 6'b111110, 7'b0011001, 1'b0, 1'b1};

        hard_reset = 1'b1;
        digits_in  = 24'd0;
        dp_in      = 6'd0;
        load       = 1'b0;
        blank_lz   = 1'b0;
        applyStimulus();
        applyStimulus();
        hard_reset = 1'b0;

        $display("[TB] decode vector table");
        for (int i = 0; i < 16; i++) begin
            digits_in = vecs[i].dig;
            dp_in     = vecs[i].dp;
            blank_lz  = vecs[i].lz;
            load      = 1'b0;
            while (pos != FRAME - 1) applyStimulus();
            load = 1'b1;
            applyStimulus();
            load = 1'b0;
            repeat (vecs[i].idx * DWELL + BLANK + 1) applyStimulus();
            checkOutput($sformatf("vec%0d_an", i), an_n, vecs[i].an);
            if (vecs[i].chk_seg) begin
                checkOutput($sformatf("vec%0d_seg", i), seg_n, vecs[i].seg);
                checkOutput($sformatf("vec%0d_dp", i), dp_n, vecs[i].dpn);
            end
        end
        blank_lz = 1'b0;

        $display("[TB] reset mid-frame");
        while (pos != 3 * DWELL + 3) applyStimulus();
        hard_reset = 1'b1;
        applyStimulus();
        applyStimulus();
        hard_reset = 1'b0;
        first_an = 0;
        first_fs = 0;
        for (int k = 1; k <= 60; k++) begin
            applyStimulus();
            if (first_an == 0 && an_n == 6'b111110) first_an = k;
            if (first_fs == 0 && frame_start == 1'b1) first_fs = k;
        end
        checkOutput("first_anode_edge", first_an, BLANK + 1);
        checkOutput("first_frame_start_edge", first_fs, FRAME);

        $display("[TB] load handshake");
        digits_in = 24'h123456;
        dp_in     = 6'd0;
        while (pos != 20) applyStimulus();
        load     = 1'b1;
        acks     = 0;
        bad_acks = 0;
        for (int k = 0; k < FRAME; k++) begin
            applyStimulus();
            if (load_ack) acks++;
            if (load_ack && !frame_start) bad_acks++;
        end
        load = 1'b0;
        checkOutput("handshake_ack_count", acks, 1);
        checkOutput("handshake_ack_without_fs", bad_acks, 0);

        $display("[TB] continuous load");
        load = 1'b1;
        acks = 0;
        for (int k = 0; k < 4 * FRAME; k++) begin
            if (pos == 10) digits_in = 24'($urandom);
            applyStimulus();
            if (load_ack) acks++;
        end
        load = 1'b0;
        checkOutput("continuous_ack_count", acks, 4);

        $display("[TB] reset at boundary");
        hard_reset = 1'b1;
        applyStimulus();
        hard_reset = 1'b0;
        digits_in  = 24'h888888;
        dp_in      = 6'h3F;
        while (pos != FRAME - 1) applyStimulus();
        load       = 1'b1;
        hard_reset = 1'b1;
        applyStimulus();
        checkOutput("boundary_reset_ack", load_ack, 1'b0);
        checkOutput("boundary_reset_fs", frame_start, 1'b0);
        hard_reset = 1'b0;
        load       = 1'b0;
        repeat (BLANK + 1) applyStimulus();
        checkOutput("boundary_reset_shadow_seg", seg_n, 7'b1000000);
        checkOutput("boundary_reset_shadow_dp", dp_n, 1'b1);

        $display("[TB] random traffic");
        for (int k = 0; k < 1500; k++) begin
            hard_reset = ($urandom_range(0, 199) == 0);
            load       = ($urandom_range(0, 3) == 0);
            blank_lz   = 1'($urandom);
            for (int d = 0; d < 6; d++) begin
                digits_in[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
                dp_in[d]            = ($urandom_range(0, 7) == 0);
            end
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
